// File: rtl/router_reg_gen.sv
// Router packet register stage: header capture, payload streaming, one-beat full
// hold, check accumulation and error flags. Optional macro: ROUTER_REG_LEN_CHECK_EN.
// Ports: clk/resetn; FSM strobes in; data_in/pkt_valid/fifo_full in;
// dout, parity_done, low_packet_valid, err, len_err, pkt_len out.
module router_reg_gen #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 4,
  parameter int CHK_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     fifo_full,
  input  logic                     detect_add,
  input  logic                     lfd_state,
  input  logic                     ld_state,
  input  logic                     laf_state,
  input  logic                     full_state,
  input  logic                     rst_int_reg,
  output logic [DATA_W-1:0]        dout,
  output logic                     parity_done,
  output logic                     low_packet_valid,
  output logic                     err,
  output logic                     len_err,
  output logic [DATA_W-ADDR_W-1:0] pkt_len
);

  localparam int LW = DATA_W - ADDR_W;
  localparam logic [31:0] NP = 32'(NUM_PORTS);

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] full_reg;
  logic [DATA_W-1:0] int_chk;
  logic [DATA_W-1:0] pkt_chk;
  logic [DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] acc_nxt;
  logic              chk_seen;
  logic              pd_q;
  logic              addr_ok;
  logic              hdr_ld;
  logic              clr;
  logic              acc_pl;
  logic              acc_hdr;
  logic              pd_set;
  logic              pd_rise;

  assign addr_ok = 32'(data_in[ADDR_W-1:0]) < NP;
  assign hdr_ld  = detect_add & pkt_valid & addr_ok;
  // A rejected header leaves every register untouched, including the clears.
  assign clr     = detect_add & ~(pkt_valid & ~addr_ok);
  assign acc_hdr = ~detect_add & lfd_state;
  assign acc_pl  = ~detect_add & ~lfd_state & ld_state
                 & pkt_valid & ~full_state;
  assign acc_in  = lfd_state ? header_reg : data_in;
  assign acc_nxt = (CHK_MODE == 1) ? int_chk + acc_in
                                   : int_chk ^ acc_in;
  assign pd_set  = (ld_state & ~fifo_full & ~pkt_valid)
                 | (laf_state & low_packet_valid & ~parity_done);
  assign pd_rise = parity_done & ~pd_q;
  assign pkt_len = header_reg[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header_reg <= '0;
    end else if (hdr_ld) begin
      header_reg <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout     <= '0;
      full_reg <= '0;
    end else begin
      unique case (1'b1)
        lfd_state:              dout     <= header_reg;
        ld_state && !fifo_full: dout     <= data_in;
        ld_state && fifo_full:  full_reg <= data_in;
        laf_state:              dout     <= full_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_chk <= '0;
    end else if (clr) begin
      int_chk <= '0;
    end else if (acc_hdr || acc_pl) begin
      int_chk <= acc_nxt;
    end
  end

  // Only the first low-pkt_valid load beat carries the check byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_chk  <= '0;
      chk_seen <= 1'b0;
    end else if (clr) begin
      chk_seen <= 1'b0;
    end else if (!detect_add && ld_state
                 && !pkt_valid && !chk_seen) begin
      pkt_chk  <= data_in;
      chk_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      low_packet_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_packet_valid <= 1'b1;
    end else if (rst_int_reg) begin
      low_packet_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_done <= 1'b0;
      pd_q        <= 1'b0;
    end else begin
      pd_q <= parity_done;
      if (clr) begin
        parity_done <= 1'b0;
      end else if (pd_set) begin
        parity_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (pd_rise) begin
      err <= (int_chk != pkt_chk);
    end
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int CW = LW + 1;

  logic [CW-1:0] beat_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (acc_pl && (beat_cnt != {CW{1'b1}})) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_err <= 1'b0;
    end else if (clr) begin
      len_err <= 1'b0;
    end else if (pd_rise) begin
      len_err <= (beat_cnt != {1'b0, pkt_len});
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench for router_reg_gen: XOR and additive check instances
// side by side, driven by hand-built packets with hand-computed results.
module tb_router_reg_gen;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;

  logic [7:0] dout0, dout1;
  logic       pd0, pd1, lpv0, lpv1;
  logic       err0, err1, lerr0, lerr1;
  logic [5:0] plen0, plen1;

  int pass_cnt = 0;
  int total    = 0;

  logic [7:0] pl  [16];
  logic [7:0] obs [17];

  always #5 clk = ~clk;

  router_reg_gen #(
    .DATA_W(8), .ADDR_W(2), .NUM_PORTS(4), .CHK_MODE(0)
  ) dut0 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout0), .parity_done(pd0),
    .low_packet_valid(lpv0), .err(err0),
    .len_err(lerr0), .pkt_len(plen0)
  );

  router_reg_gen #(
    .DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout1), .parity_done(pd1),
    .low_packet_valid(lpv1), .err(err1),
    .len_err(lerr1), .pkt_len(plen1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid   = 1'b0;
    data_in     = 8'h00;
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  // Drives header, lfd, n payload beats from pl[], then the check beat.
  task automatic send_pkt(input logic [7:0] hdr, input int n,
                          input logic [7:0] chk);
    idle_inputs();
    detect_add  = 1'b1;
    pkt_valid   = 1'b1;
    rst_int_reg = 1'b1;
    data_in     = hdr;
    step();
    detect_add  = 1'b0;
    rst_int_reg = 1'b0;
    lfd_state   = 1'b1;
    data_in     = 8'h00;
    step();
    obs[0]    = dout0;
    lfd_state = 1'b0;
    ld_state  = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = pl[i];
      step();
      obs[i+1] = dout0;
    end
    pkt_valid = 1'b0;
    data_in   = chk;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    total++;
    if ({dout0, pd0, lpv0, err0, lerr0, plen0} !== 18'd0) begin
      $display("FAIL reset_dut0 got %h want 0",
               {dout0, pd0, lpv0, err0, lerr0, plen0});
    end else pass_cnt++;
    total++;
    if ({dout1, pd1, lpv1, err1, lerr1, plen1} !== 18'd0) begin
      $display("FAIL reset_dut1 got %h want 0",
               {dout1, pd1, lpv1, err1, lerr1, plen1});
    end else pass_cnt++;
  endtask

  task automatic test_xor_good();
    logic [7:0] exp_d [9];
    exp_d = '{8'h22, 8'h01, 8'h02, 8'h04, 8'h08,
              8'h10, 8'h20, 8'h40, 8'h80};
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h04; pl[3] = 8'h08;
    pl[4] = 8'h10; pl[5] = 8'h20; pl[6] = 8'h40; pl[7] = 8'h80;
    send_pkt(8'h22, 8, 8'hDD);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (obs[i] !== exp_d[i]) begin
        $display("FAIL xor_dout[%0d] got %h want %h", i, obs[i], exp_d[i]);
      end else pass_cnt++;
    end
    total++;
    if (pd0 !== 1'b1) $display("FAIL xor_parity_done got %b want 1", pd0);
    else pass_cnt++;
    total++;
    if (lpv0 !== 1'b1) $display("FAIL xor_lpv got %b want 1", lpv0);
    else pass_cnt++;
    total++;
    if (plen0 !== 6'd8) $display("FAIL xor_pkt_len got %0d want 8", plen0);
    else pass_cnt++;
    step();
    total++;
    if (err0 !== 1'b0) $display("FAIL xor_err got %b want 0", err0);
    else pass_cnt++;
    total++;
    if (lerr0 !== 1'b0) $display("FAIL xor_len_err got %b want 0", lerr0);
    else pass_cnt++;
  endtask

  task automatic test_err_hold();
    send_pkt(8'h22, 8, 8'h22);
    total++;
    if (err0 !== 1'b0) $display("FAIL bad_err_early got %b want 0", err0);
    else pass_cnt++;
    step();
    total++;
    if (err0 !== 1'b1) $display("FAIL bad_err got %b want 1", err0);
    else pass_cnt++;
    step(); step(); step();
    total++;
    if (err0 !== 1'b1) $display("FAIL bad_err_hold got %b want 1", err0);
    else pass_cnt++;
    detect_add  = 1'b1;
    pkt_valid   = 1'b1;
    rst_int_reg = 1'b1;
    data_in     = 8'h22;
    step();
    idle_inputs();
    total++;
    if (err0 !== 1'b0) $display("FAIL bad_err_clear got %b want 0", err0);
    else pass_cnt++;
    total++;
    if (pd0 !== 1'b0) $display("FAIL pd_clear got %b want 0", pd0);
    else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    idle_inputs();
    detect_add  = 1'b1;
    pkt_valid   = 1'b1;
    rst_int_reg = 1'b1;
    data_in     = 8'h0A;
    step();
    detect_add  = 1'b0;
    rst_int_reg = 1'b0;
    lfd_state   = 1'b1;
    data_in     = 8'h00;
    step();
    lfd_state = 1'b0;
    ld_state  = 1'b1;
    data_in   = 8'h11;
    step();
    total++;
    if (dout0 !== 8'h11) $display("FAIL full_pre got %h want 11", dout0);
    else pass_cnt++;
    data_in   = 8'h5A;
    fifo_full = 1'b1;
    step();
    total++;
    if (dout0 !== 8'h11) $display("FAIL full_hold got %h want 11", dout0);
    else pass_cnt++;
    ld_state   = 1'b0;
    full_state = 1'b1;
    data_in    = 8'hEE;
    step();
    total++;
    if (dout0 !== 8'h11) $display("FAIL full_wait got %h want 11", dout0);
    else pass_cnt++;
    full_state = 1'b0;
    fifo_full  = 1'b0;
    laf_state  = 1'b1;
    step();
    total++;
    if (dout0 !== 8'h5A) $display("FAIL laf_dout got %h want 5a", dout0);
    else pass_cnt++;
    total++;
    if (pd0 !== 1'b0) $display("FAIL laf_pd got %b want 0", pd0);
    else pass_cnt++;
    laf_state = 1'b0;
    ld_state  = 1'b1;
    pkt_valid = 1'b0;
    data_in   = 8'h41;
    step();
    idle_inputs();
    total++;
    if (pd0 !== 1'b1) $display("FAIL full_pd got %b want 1", pd0);
    else pass_cnt++;
    step();
    total++;
    if (err0 !== 1'b0) $display("FAIL full_err got %b want 0", err0);
    else pass_cnt++;
  endtask

  task automatic test_len_short();
    logic exp_le;
`ifdef ROUTER_REG_LEN_CHECK_EN
    exp_le = 1'b1;
`else
    exp_le = 1'b0;
`endif
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h04; pl[3] = 8'h08;
    pl[4] = 8'h10; pl[5] = 8'h20; pl[6] = 8'h40;
    send_pkt(8'h22, 7, 8'h5D);
    total++;
    if (lerr0 !== 1'b0) $display("FAIL len_early got %b want 0", lerr0);
    else pass_cnt++;
    step();
    total++;
    if (err0 !== 1'b0) $display("FAIL len_err_chk got %b want 0", err0);
    else pass_cnt++;
    total++;
    if (lerr0 !== exp_le) begin
      $display("FAIL len_short got %b want %b", lerr0, exp_le);
    end else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    detect_add  = 1'b1;
    pkt_valid   = 1'b1;
    rst_int_reg = 1'b1;
    data_in     = 8'h22;
    step();
    detect_add  = 1'b0;
    rst_int_reg = 1'b0;
    lfd_state   = 1'b1;
    step();
    lfd_state = 1'b0;
    ld_state  = 1'b1;
    data_in   = 8'h01;
    step();
    data_in = 8'h02;
    step();
    total++;
    if (dout0 !== 8'h02) $display("FAIL pre_rst_dout got %h want 02", dout0);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({dout0, pd0, lpv0, err0, lerr0, plen0} !== 18'd0) begin
      $display("FAIL async_rst_dut0 got %h want 0",
               {dout0, pd0, lpv0, err0, lerr0, plen0});
    end else pass_cnt++;
    total++;
    if ({dout1, pd1, lpv1, err1, lerr1, plen1} !== 18'd0) begin
      $display("FAIL async_rst_dut1 got %h want 0",
               {dout1, pd1, lpv1, err1, lerr1, plen1});
    end else pass_cnt++;
    idle_inputs();
    step();
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic test_sum_mode();
    pl[0] = 8'hF0; pl[1] = 8'h20; pl[2] = 8'h01;
    send_pkt(8'h0E, 3, 8'h1F);
    total++;
    if (pd1 !== 1'b1) $display("FAIL sum_pd got %b want 1", pd1);
    else pass_cnt++;
    step();
    total++;
    if (err1 !== 1'b0) $display("FAIL sum_good_err got %b want 0", err1);
    else pass_cnt++;
    total++;
    if (plen1 !== 6'd3) $display("FAIL sum_pkt_len got %0d want 3", plen1);
    else pass_cnt++;
    send_pkt(8'h0E, 3, 8'h1E);
    step();
    total++;
    if (err1 !== 1'b1) $display("FAIL sum_bad_err got %b want 1", err1);
    else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    idle_inputs();
    detect_add  = 1'b1;
    pkt_valid   = 1'b1;
    rst_int_reg = 1'b1;
    data_in     = 8'h23;
    step();
    idle_inputs();
    total++;
    if (plen1 !== 6'd3) $display("FAIL badaddr_len got %0d want 3", plen1);
    else pass_cnt++;
    total++;
    if (pd1 !== 1'b1) $display("FAIL badaddr_pd got %b want 1", pd1);
    else pass_cnt++;
    total++;
    if (err1 !== 1'b1) $display("FAIL badaddr_err got %b want 1", err1);
    else pass_cnt++;
    total++;
    if (plen0 !== 6'd8) $display("FAIL goodaddr_len got %0d want 8", plen0);
    else pass_cnt++;
    total++;
    if (pd0 !== 1'b0) $display("FAIL goodaddr_pd got %b want 0", pd0);
    else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    #3;
    test_reset();
    #20 resetn = 1'b1;
    step();
    test_xor_good();
    test_err_hold();
    test_fifo_full();
    test_len_short();
    test_mid_reset();
    test_sum_mode();
    test_bad_addr();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
